// File: rtl/score_keeper.sv
// score_keeper: frame-driven game score with hold-to-repeat counting,
// collision freeze, high-score tracking and a sequential BCD copy.
module score_keeper #(
  parameter int HOLD_FRAMES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_move,
  input  logic        i_collision,
  input  logic        i_restart,
  output logic [7:0]  o_score,
  output logic [7:0]  o_high_score,
  output logic [11:0] o_bcd,
  output logic        o_bcd_valid,
  output logic        o_game_over
);

  // Game FSM
  //   state | meaning
  //   PLAY  | game running, ticks with move held add to the score
  //   OVER  | collision seen, score frozen until restart
  //
  // Converter FSM
  //   state   | meaning
  //   C_IDLE  | o_bcd current, watching o_score for a change
  //   C_SHIFT | double-dabble in progress, 8 shift cycles

  localparam int RW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(HOLD_FRAMES - 1);

  typedef enum logic {PLAY, OVER} game_t;
  typedef enum logic {C_IDLE, C_SHIFT} conv_t;

  game_t          state, state_next;
  conv_t          conv_state, conv_next;
  logic [RW-1:0]  rep_cnt;
  logic [7:0]     conv_src;
  logic [7:0]     conv_lat;
  logic [7:0]     src_sh, src_next;
  logic [11:0]    acc, acc_adj, acc_next;
  logic [2:0]     shift_cnt;
  logic           conv_start, conv_done;

  // Game state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= PLAY;
    else       state <= state_next;
  end

  // Game next-state: restart outranks collision
  always_comb begin
    state_next = state;
    if (i_restart)                          state_next = PLAY;
    else if (state == PLAY && i_collision)  state_next = OVER;
  end

  // Game outputs
  always_comb begin
    o_game_over = (state == OVER);
  end

  // Score, high score and hold-repeat counter; collision blocks the tick
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_score      <= 8'd0;
      o_high_score <= 8'd0;
      rep_cnt      <= '0;
    end else if (i_restart) begin
      o_score <= 8'd0;
      rep_cnt <= '0;
    end else if (state == PLAY) begin
      if (i_collision) begin
        if (o_score > o_high_score) o_high_score <= o_score;
      end else if (i_frame_tick) begin
        if (i_move) begin
          if (rep_cnt == '0 && o_score != 8'hFF) o_score <= o_score + 8'd1;
          rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
        end else begin
          rep_cnt <= '0;
        end
      end
    end
  end

  // Converter state register
  always_ff @(posedge i_clk) begin
    if (i_rst) conv_state <= C_IDLE;
    else       conv_state <= conv_next;
  end

  // Converter next-state
  always_comb begin
    conv_next = conv_state;
    if (conv_start)     conv_next = C_SHIFT;
    else if (conv_done) conv_next = C_IDLE;
  end

  // Converter control decode
  always_comb begin
    conv_start = (conv_state == C_IDLE) && (o_score != conv_src);
    conv_done  = (conv_state == C_SHIFT) && (shift_cnt == 3'd7);
  end

  // One double-dabble step: add-3 on nibbles >= 5, then shift left
  always_comb begin
    acc_adj = acc;
    for (int n = 0; n < 3; n++) begin
      if (acc[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
    {acc_next, src_next} = {acc_adj, src_sh} << 1;
  end

  // Converter datapath; o_bcd only ever takes a finished result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conv_src    <= 8'd0;
      conv_lat    <= 8'd0;
      src_sh      <= 8'd0;
      acc         <= 12'd0;
      shift_cnt   <= 3'd0;
      o_bcd       <= 12'h000;
      o_bcd_valid <= 1'b1;
    end else if (conv_start) begin
      conv_lat    <= o_score;
      src_sh      <= o_score;
      acc         <= 12'd0;
      shift_cnt   <= 3'd0;
      o_bcd_valid <= 1'b0;
    end else if (conv_state == C_SHIFT) begin
      acc       <= acc_next;
      src_sh    <= src_next;
      shift_cnt <= shift_cnt + 3'd1;
      if (conv_done) begin
        o_bcd       <= acc_next;
        conv_src    <= conv_lat;
        o_bcd_valid <= (o_score == conv_lat);
      end
    end else begin
      o_bcd_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random stimulus on two instances
// (HOLD_FRAMES 8 and 1) checked against a frame-level game model.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1, tick = 1'b0, move = 1'b0, coll = 1'b0, restart = 1'b0;

  logic [7:0]  score_o [2];
  logic [7:0]  high_o  [2];
  logic [11:0] bcd_o   [2];
  logic        valid_o [2];
  logic        over_o  [2];

  int checks = 0;
  int errors = 0;

  int hold    [2] = '{8, 1};
  int m_score [2];
  int m_high  [2];
  int m_held  [2];
  int m_prev  [2];
  bit m_over  [2];

  always #5 clk = ~clk;

  score_keeper #(.HOLD_FRAMES(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_move(move),
    .i_collision(coll), .i_restart(restart),
    .o_score(score_o[0]), .o_high_score(high_o[0]), .o_bcd(bcd_o[0]),
    .o_bcd_valid(valid_o[0]), .o_game_over(over_o[0])
  );

  score_keeper #(.HOLD_FRAMES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_move(move),
    .i_collision(coll), .i_restart(restart),
    .o_score(score_o[1]), .o_high_score(high_o[1]), .o_bcd(bcd_o[1]),
    .o_bcd_valid(valid_o[1]), .o_game_over(over_o[1])
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Score advances on the 1st, (1+hold)th, (1+2*hold)th ... held frame.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = m_score[i];
      if (rst) begin
        m_score[i] = 0; m_high[i] = 0; m_held[i] = 0; m_over[i] = 0;
      end else if (restart) begin
        m_score[i] = 0; m_held[i] = 0; m_over[i] = 0;
      end else if (!m_over[i] && coll) begin
        m_over[i] = 1;
        if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
      end else if (!m_over[i] && tick) begin
        if (move) begin
          if (m_held[i] % hold[i] == 0 && m_score[i] < 255) m_score[i]++;
          m_held[i]++;
        end else begin
          m_held[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d score", i), 32'(score_o[i]), 32'(m_score[i]));
      check($sformatf("d%0d high", i), 32'(high_o[i]), 32'(m_high[i]));
      check($sformatf("d%0d over", i), 32'(over_o[i]), 32'(m_over[i]));
      if (valid_o[i] === 1'b1 && m_prev[i] == m_score[i])
        check($sformatf("d%0d bcd", i), 32'(bcd_o[i]), 32'(to_bcd(m_score[i])));
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic c, input logic s);
    rst = r; tick = t; coll = c; restart = s;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic wait_valid(input int i);
    int n;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n = 0;
    while (valid_o[i] !== 1'b1 && n < 30) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    check($sformatf("d%0d valid settle", i), 32'(valid_o[i]), 32'd1);
    check($sformatf("d%0d bcd settle", i), 32'(bcd_o[i]), 32'(to_bcd(m_score[i])));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0; m_high[i] = 0; m_held[i] = 0; m_prev[i] = 0; m_over[i] = 0;
    end

    // Reset values
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d rst bcd", i), 32'(bcd_o[i]), 32'h000);
      check($sformatf("d%0d rst valid", i), 32'(valid_o[i]), 32'd1);
      check($sformatf("d%0d rst score", i), 32'(score_o[i]), 32'd0);
      check($sformatf("d%0d rst over", i), 32'(over_o[i]), 32'd0);
    end

    // Hold for 20 ticks, release one tick, press again
    move = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check("hold20 d8 score", 32'(score_o[0]), 32'd3);
    check("hold20 d1 score", 32'(score_o[1]), 32'd20);
    move = 1'b0;
    cyc(0, 1, 0, 0);
    move = 1'b1;
    cyc(0, 1, 0, 0);
    check("repress d8 score", 32'(score_o[0]), 32'd4);
    wait_valid(0);
    wait_valid(1);

    // BCD latency at 137
    cyc(1, 0, 0, 0);
    move = 1'b1;
    for (int k = 0; k < 136; k++) cyc(0, 1, 0, 0);
    wait_valid(1);
    cyc(0, 1, 0, 0);
    check("lat d1 score", 32'(score_o[1]), 32'd137);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 0);
      check($sformatf("lat valid N+%0d", k), 32'(valid_o[1]), 32'd0);
      check($sformatf("lat bcd hold N+%0d", k), 32'(bcd_o[1]), 32'h136);
    end
    cyc(0, 0, 0, 0);
    check("lat valid N+9", 32'(valid_o[1]), 32'd1);
    check("lat bcd N+9", 32'(bcd_o[1]), 32'h137);

    // Saturation
    for (int k = 0; k < 300; k++) cyc(0, 1, 0, 0);
    check("sat score", 32'(score_o[1]), 32'd255);
    wait_valid(1);
    check("sat bcd", 32'(bcd_o[1]), 32'h255);

    // Collision at 42 coinciding with a held tick
    cyc(1, 0, 0, 0);
    move = 1'b1;
    for (int k = 0; k < 42; k++) cyc(0, 1, 0, 0);
    wait_valid(1);
    cyc(0, 1, 1, 0);
    check("coll score", 32'(score_o[1]), 32'd42);
    check("coll over", 32'(over_o[1]), 32'd1);
    check("coll high", 32'(high_o[1]), 32'd42);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0);
    check("over frozen", 32'(score_o[1]), 32'd42);
    move = 1'b0;
    cyc(0, 0, 0, 1);
    check("restart score", 32'(score_o[1]), 32'd0);
    check("restart over", 32'(over_o[1]), 32'd0);
    check("restart high", 32'(high_o[1]), 32'd42);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0);
    check("restart bcd N+9", 32'(bcd_o[1]), 32'h000);
    check("restart valid N+9", 32'(valid_o[1]), 32'd1);
    move = 1'b1;
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    check("game2 score", 32'(score_o[1]), 32'd10);
    check("game2 high", 32'(high_o[1]), 32'd42);

    // Reset four cycles into a conversion
    cyc(0, 0, 0, 1);
    wait_valid(1);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d midrst score", i), 32'(score_o[i]), 32'd0);
      check($sformatf("d%0d midrst high", i), 32'(high_o[i]), 32'd0);
      check($sformatf("d%0d midrst bcd", i), 32'(bcd_o[i]), 32'h000);
      check($sformatf("d%0d midrst valid", i), 32'(valid_o[i]), 32'd1);
      check($sformatf("d%0d midrst over", i), 32'(over_o[i]), 32'd0);
    end

    // Simultaneous restart and collision
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 1);
    check("rc score", 32'(score_o[1]), 32'd0);
    check("rc over", 32'(over_o[1]), 32'd0);
    check("rc high", 32'(high_o[1]), 32'd5);

    // Random play
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      move = ($urandom_range(99, 0) < 75);
      cyc($urandom_range(499, 0) == 0, $urandom_range(99, 0) < 50,
          $urandom_range(39, 0) == 0, $urandom_range(59, 0) == 0);
    end
    move = 1'b0;
    wait_valid(0);
    wait_valid(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
